// File: rtl/ram_q_ctrl_pkg.sv
// Shared sizing defaults and controller state encoding for the RAM_Q column controller.
package ram_q_ctrl_pkg;

    localparam int NUM_COL_DEF = 8;
    localparam int LANES_DEF   = 64;
    localparam int LANE_AW_DEF = 9;
    localparam int LANE_DW_DEF = 19;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/ram_q_ctrl_addr_gen.sv
// Expands a column index into the per-lane RAM_Q address bus; every lane i gets {col, i}.
module ram_q_addr_gen
    import ram_q_ctrl_pkg::*;
#(
    parameter  int NUM_COL = NUM_COL_DEF,
    parameter  int LANES   = LANES_DEF,
    parameter  int LANE_AW = LANE_AW_DEF,
    localparam int CW      = $clog2(NUM_COL)
) (
    input  logic [CW-1:0]              col,
    output logic [LANES*LANE_AW-1:0]   addr
);

    localparam int LW = $clog2(LANES);

    always_comb begin
        addr = '0;
        for (int i = 0; i < LANES; i++) begin
            addr[i*LANE_AW +: LANE_AW] = LANE_AW'({col, LW'(i)});
        end
    end

endmodule

// File: rtl/ram_q_ctrl.sv
// Column-wide RAM_Q controller: round-robin write/read arbitration plus a sequenced zero-clear.
//   state    | meaning
//   ST_IDLE  | accepting writes/reads, one RAM access per cycle
//   ST_CLEAR | writing zeros to columns 0..NUM_COL-1, one per cycle
module ram_q_ctrl
    import ram_q_ctrl_pkg::*;
#(
    parameter  int NUM_COL = NUM_COL_DEF,
    parameter  int LANES   = LANES_DEF,
    parameter  int LANE_AW = LANE_AW_DEF,
    parameter  int LANE_DW = LANE_DW_DEF,
    localparam int CW      = $clog2(NUM_COL)
) (
    input  logic                       CK,
    input  logic                       RSTn,
    input  logic                       clr_req,
    output logic                       clr_busy,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [CW-1:0]              wr_col,
    input  logic [LANES*LANE_DW-1:0]   wr_data,
    input  logic                       rd_valid,
    output logic                       rd_ready,
    input  logic [CW-1:0]              rd_col,
    output logic                       rd_data_valid,
    output logic [LANES*LANE_DW-1:0]   rd_data,
    output logic                       rd_err,
    output logic [NUM_COL-1:0]         col_valid,
    output logic [LANES*LANE_AW-1:0]   ram_A,
    output logic                       ram_WE,
    output logic                       ram_OE,
    output logic [LANES*LANE_DW-1:0]   ram_D,
    input  logic [LANES*LANE_DW-1:0]   ram_Q
);

    state_t                     state;
    logic [CW-1:0]              clr_cnt;
    logic                       ready_en;
    logic                       last_wr;
    logic                       rd_pend;
    logic                       rd_err_q;
    logic [NUM_COL-1:0]         col_valid_q;
    logic [LANES*LANE_AW-1:0]   ram_a_q;
    logic [LANES*LANE_AW-1:0]   addr_now;
    logic                       idle_ok;
    logic                       clearing;
    logic                       wr_go;
    logic                       rd_go;
    logic                       access;
    logic [CW-1:0]              acc_col;

    // A pending clr_req blocks both grants; on contention the side granted last yields.
    assign clearing = (state == ST_CLEAR);
    assign idle_ok  = ready_en && !clearing && !clr_req;
    assign wr_ready = idle_ok && !(rd_valid && last_wr);
    assign rd_ready = idle_ok && !(wr_valid && !last_wr);
    assign wr_go    = wr_valid && wr_ready;
    assign rd_go    = rd_valid && rd_ready;
    assign access   = clearing || wr_go || rd_go;
    assign acc_col  = clearing ? clr_cnt : (wr_go ? wr_col : rd_col);

    ram_q_addr_gen #(
        .NUM_COL (NUM_COL),
        .LANES   (LANES),
        .LANE_AW (LANE_AW)
    ) u_addr_gen (
        .col  (acc_col),
        .addr (addr_now)
    );

    assign ram_A         = access ? addr_now : ram_a_q;
    assign ram_WE        = clearing || wr_go;
    assign ram_D         = wr_go ? wr_data : '0;
    assign ram_OE        = rd_pend;
    assign rd_data_valid = rd_pend;
    assign rd_data       = rd_pend ? ram_Q : '0;
    assign rd_err        = rd_pend && rd_err_q;
    assign clr_busy      = clearing;
    assign col_valid     = col_valid_q;

    always_ff @(posedge CK or negedge RSTn) begin
        if (!RSTn) begin
            state       <= ST_IDLE;
            clr_cnt     <= '0;
            ready_en    <= 1'b0;
            last_wr     <= 1'b0;
            rd_pend     <= 1'b0;
            rd_err_q    <= 1'b0;
            col_valid_q <= '0;
            ram_a_q     <= '0;
        end else begin
            ready_en <= 1'b1;
            rd_pend  <= rd_go;
            if (rd_go) begin
                rd_err_q <= ~col_valid_q[rd_col];
            end
            if (access) begin
                ram_a_q <= addr_now;
            end
            if (wr_go) begin
                last_wr <= 1'b1;
            end else if (rd_go) begin
                last_wr <= 1'b0;
            end
            if (state == ST_IDLE) begin
                if (ready_en && clr_req) begin
                    state       <= ST_CLEAR;
                    clr_cnt     <= '0;
                    col_valid_q <= '0;
                end else if (wr_go) begin
                    col_valid_q[wr_col] <= 1'b1;
                end
            end else begin
                if (clr_cnt == CW'(NUM_COL - 1)) begin
                    state <= ST_IDLE;
                end else begin
                    clr_cnt <= clr_cnt + CW'(1);
                end
            end
        end
    end

endmodule
